// File: rtl/wf_neopixel_frame_sched_pkg.sv
// Shared types and constants for the double-buffered neopixel frame scheduler.
package wf_neopixel_frame_sched_pkg;

    localparam int PIXEL_W = 24;

    typedef enum logic [1:0] {
        ST_FILL    = 2'd0,
        ST_PENDING = 2'd1,
        ST_CLEAR   = 2'd2
    } state_t;

endpackage

// File: rtl/wf_pixel_dpram.sv
// Two-buffer pixel store: one write port, one registered read port.
// Each port selects a buffer half and a pixel index within it.
module wf_pixel_dpram
    import wf_neopixel_frame_sched_pkg::*;
#(
    parameter int HALF = 8
) (
    input  logic               clk,
    input  logic               we,
    input  logic               wr_sel,
    input  logic [7:0]         wr_addr,
    input  logic [PIXEL_W-1:0] wr_data,
    input  logic               rd_sel,
    input  logic [7:0]         rd_addr,
    output logic [PIXEL_W-1:0] rd_data
);

    localparam int DEPTH = 2 * HALF;
    localparam int AW    = $clog2(DEPTH);

    logic [PIXEL_W-1:0] mem [DEPTH];
    logic [AW-1:0]      wi;
    logic [AW-1:0]      ri;

    // Out-of-range read indices only ever produce data that the caller masks.
    assign wi = AW'({1'b0, wr_addr} + (wr_sel ? 9'(HALF) : 9'd0));
    assign ri = AW'({1'b0, rd_addr} + (rd_sel ? 9'(HALF) : 9'd0));

    // No reset here so the array and output register map onto block RAM.
    always_ff @(posedge clk) begin
        if (we)
            mem[wi] <= wr_data;
        rd_data <= mem[ri];
    end

endmodule

// File: rtl/wf_neopixel_frame_sched.sv
// Frame scheduler: round-robin pixel writes into the back buffer, swaps
// deferred to the next frame boundary, optional clear of the new back buffer.
module wf_neopixel_frame_sched
    import wf_neopixel_frame_sched_pkg::*;
#(
    parameter int          NUM_OF_PIXELS = 8,
    parameter logic        CLEAR_ON_SWAP = 1'b1,
    parameter logic [23:0] CLEAR_COLOR   = 24'h0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_a,
    input  logic [7:0]  wr_addr_a,
    input  logic [23:0] wr_data_a,
    output logic        gnt_a,
    input  logic        req_b,
    input  logic [7:0]  wr_addr_b,
    input  logic [23:0] wr_data_b,
    output logic        gnt_b,
    input  logic        swap_req,
    output logic        swap_pending,
    input  logic [7:0]  ram_rd_addr,
    output logic [23:0] ram_rd_data,
    output logic        frame_done
);

    localparam logic [7:0] NPIX = 8'(NUM_OF_PIXELS);
    localparam logic [7:0] LAST = 8'(NUM_OF_PIXELS - 1);

    state_t             state;
    logic               front_sel;
    logic               rr_ptr;      // 0: A has priority, 1: B
    logic               prev_nz;
    logic               rd_ok;
    logic [7:0]         clr_cnt;
    logic               boundary;
    logic               fill;
    logic               we;
    logic [7:0]         waddr;
    logic [PIXEL_W-1:0] wdata;
    logic [PIXEL_W-1:0] ram_q;

    assign boundary = prev_nz && (ram_rd_addr == 8'd0);
    assign fill     = (state == ST_FILL);

    assign gnt_a = fill && req_a && (!req_b || !rr_ptr);
    assign gnt_b = fill && req_b && (!req_a ||  rr_ptr);

    // Reset blocks the write so an aborted clear leaves no trailing pixel.
    always_comb begin
        we    = 1'b0;
        waddr = wr_addr_a;
        wdata = wr_data_a;
        if (state == ST_CLEAR) begin
            we    = 1'b1;
            waddr = clr_cnt;
            wdata = CLEAR_COLOR;
        end else if (gnt_a) begin
            we    = (wr_addr_a < NPIX);
        end else if (gnt_b) begin
            we    = (wr_addr_b < NPIX);
            waddr = wr_addr_b;
            wdata = wr_data_b;
        end
        we = we && rst_n;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= ST_FILL;
            front_sel    <= 1'b0;
            rr_ptr       <= 1'b0;
            swap_pending <= 1'b0;
            frame_done   <= 1'b0;
            prev_nz      <= 1'b0;
            rd_ok        <= 1'b0;
            clr_cnt      <= 8'd0;
        end else begin
            frame_done <= boundary;
            prev_nz    <= (ram_rd_addr != 8'd0);
            rd_ok      <= (ram_rd_addr < NPIX);
            if (gnt_a && req_b)
                rr_ptr <= 1'b1;
            else if (gnt_b && req_a)
                rr_ptr <= 1'b0;
            case (state)
                ST_FILL: begin
                    if (swap_req) begin
                        state        <= ST_PENDING;
                        swap_pending <= 1'b1;
                    end
                end
                ST_PENDING: begin
                    if (boundary) begin
                        front_sel <= ~front_sel;
                        clr_cnt   <= 8'd0;
                        if (CLEAR_ON_SWAP) begin
                            state <= ST_CLEAR;
                        end else begin
                            state        <= ST_FILL;
                            swap_pending <= 1'b0;
                        end
                    end
                end
                ST_CLEAR: begin
                    if (clr_cnt == LAST) begin
                        state        <= ST_FILL;
                        swap_pending <= 1'b0;
                    end else begin
                        clr_cnt <= clr_cnt + 8'd1;
                    end
                end
                default: state <= ST_FILL;
            endcase
        end
    end

    wf_pixel_dpram #(.HALF(NUM_OF_PIXELS)) u_ram (
        .clk     (clk),
        .we      (we),
        .wr_sel  (~front_sel),
        .wr_addr (waddr),
        .wr_data (wdata),
        .rd_sel  (front_sel),
        .rd_addr (ram_rd_addr),
        .rd_data (ram_q)
    );

    // rd_ok masks out-of-range indices and the unreset RAM output after reset.
    assign ram_rd_data = rd_ok ? ram_q : 24'h0;

endmodule

// File: tb/tb_wf_neopixel_frame_sched.sv
// Directed bench for the neopixel frame scheduler (8 pixels, clear to zero).
module tb_wf_neopixel_frame_sched;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_a, req_b, swap_req;
    logic [7:0]  wr_addr_a, wr_addr_b, ram_rd_addr;
    logic [23:0] wr_data_a, wr_data_b;
    logic        gnt_a, gnt_b, swap_pending, frame_done;
    logic [23:0] ram_rd_data;

    int total = 0;
    int bad   = 0;

    wf_neopixel_frame_sched #(
        .NUM_OF_PIXELS (8),
        .CLEAR_ON_SWAP (1'b1),
        .CLEAR_COLOR   (24'h0)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_a        (req_a),
        .wr_addr_a    (wr_addr_a),
        .wr_data_a    (wr_data_a),
        .gnt_a        (gnt_a),
        .req_b        (req_b),
        .wr_addr_b    (wr_addr_b),
        .wr_data_b    (wr_data_b),
        .gnt_b        (gnt_b),
        .swap_req     (swap_req),
        .swap_pending (swap_pending),
        .ram_rd_addr  (ram_rd_addr),
        .ram_rd_data  (ram_rd_data),
        .frame_done   (frame_done)
    );

    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #2;
    endtask

    // Swap plus one boundary, then wait out the 8-cycle clear.
    task automatic do_swap;
        swap_req = 1'b1; ram_rd_addr = 8'd1; step();
        swap_req = 1'b0; step();
        ram_rd_addr = 8'd0; step();
        repeat (8) step();
    endtask

    task automatic read_px(input logic [7:0] a, input logic [23:0] exp, input string name);
        ram_rd_addr = a;
        step();
        total++;
        if (ram_rd_data !== exp) begin
            bad++;
            $display("FAIL %s addr=%0d got=%h exp=%h", name, a, ram_rd_data, exp);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        step(); step();
        total++; if (swap_pending !== 1'b0) begin bad++; $display("FAIL rst_swap_pending got=%b exp=0", swap_pending); end
        total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL rst_frame_done got=%b exp=0", frame_done); end
        total++; if (ram_rd_data !== 24'h0) begin bad++; $display("FAIL rst_rd_data got=%h exp=0", ram_rd_data); end
        rst_n = 1'b1;
        step();
        // Clear both buffers so later reads have known contents; front ends on buffer 0.
        do_swap();
        do_swap();
    endtask

    task automatic test_basic_write;
        req_a = 1'b1; wr_addr_a = 8'd2; wr_data_a = 24'h112233;
        #1;
        total++; if (gnt_a !== 1'b1 || gnt_b !== 1'b0) begin bad++; $display("FAIL basic_gnt got=%b%b exp=10", gnt_a, gnt_b); end
        step();
        req_a = 1'b0;
        do_swap();
        read_px(8'd2, 24'h112233, "basic_read");
        read_px(8'd3, 24'h0, "basic_cleared");
    endtask

    task automatic test_round_robin;
        req_a = 1'b1; wr_addr_a = 8'd4; wr_data_a = 24'hAAAA01;
        req_b = 1'b1; wr_addr_b = 8'd5; wr_data_b = 24'hBBBB01;
        for (int i = 0; i < 4; i++) begin
            #1;
            total++;
            if (gnt_a !== (i % 2 == 0) || gnt_b !== (i % 2 == 1)) begin
                bad++; $display("FAIL rr_cycle%0d got=%b%b exp=%b%b", i, gnt_a, gnt_b, i % 2 == 0, i % 2 == 1);
            end
            step();
        end
        req_a = 1'b0; wr_addr_b = 8'd7; wr_data_b = 24'h0B0B0B;
        for (int i = 0; i < 2; i++) begin
            #1;
            total++; if (gnt_b !== 1'b1 || gnt_a !== 1'b0) begin bad++; $display("FAIL rr_solo_b%0d got=%b%b exp=01", i, gnt_a, gnt_b); end
            step();
        end
        req_b = 1'b0;
        do_swap();
        read_px(8'd4, 24'hAAAA01, "rr_a_write");
        read_px(8'd5, 24'hBBBB01, "rr_b_write");
        read_px(8'd7, 24'h0B0B0B, "rr_b_solo");
        read_px(8'd2, 24'h0, "rr_back_cleared");
    endtask

    task automatic test_swap_defer;
        req_a = 1'b1; wr_addr_a = 8'd1; wr_data_a = 24'h00ABCD;
        #1;
        total++; if (gnt_a !== 1'b1) begin bad++; $display("FAIL defer_prewrite got=%b exp=1", gnt_a); end
        step();
        req_a = 1'b0;
        wr_addr_a = 8'd6; wr_data_a = 24'h660066;
        for (int a = 1; a < 8; a++) begin
            ram_rd_addr = 8'(a);
            swap_req = (a == 1) || (a == 3);
            req_a = (a >= 2);
            #1;
            if (a >= 2) begin
                total++; if (gnt_a !== 1'b0) begin bad++; $display("FAIL pend_gnt a=%0d got=%b exp=0", a, gnt_a); end
            end
            step();
            total++; if (swap_pending !== 1'b1 || frame_done !== 1'b0) begin bad++; $display("FAIL pend_flags a=%0d got=%b%b exp=10", a, swap_pending, frame_done); end
            if (a == 4) begin
                total++; if (ram_rd_data !== 24'hAAAA01) begin bad++; $display("FAIL pend_front got=%h exp=aaaa01", ram_rd_data); end
            end
        end
        swap_req = 1'b0;
        ram_rd_addr = 8'd0;
        #1;
        total++; if (gnt_a !== 1'b0) begin bad++; $display("FAIL boundary_gnt got=%b exp=0", gnt_a); end
        step();
        total++; if (frame_done !== 1'b1 || swap_pending !== 1'b1) begin bad++; $display("FAIL boundary_flags got=%b%b exp=11", frame_done, swap_pending); end
        for (int k = 0; k < 8; k++) begin
            ram_rd_addr = (k == 0) ? 8'd1 : 8'd2;
            swap_req = (k == 2);
            #1;
            total++; if (gnt_a !== 1'b0) begin bad++; $display("FAIL clear_gnt k=%0d got=%b exp=0", k, gnt_a); end
            step();
            total++; if (swap_pending !== (k != 7)) begin bad++; $display("FAIL clear_pending k=%0d got=%b exp=%b", k, swap_pending, k != 7); end
            if (k == 0) begin
                total++; if (ram_rd_data !== 24'h00ABCD || frame_done !== 1'b0) begin bad++; $display("FAIL new_front got=%h/%b exp=00abcd/0", ram_rd_data, frame_done); end
            end
        end
        swap_req = 1'b0;
        #1;
        total++; if (gnt_a !== 1'b1) begin bad++; $display("FAIL fill_regrant got=%b exp=1", gnt_a); end
        step();
        req_a = 1'b0;
        // The ignored swap_req pulses must not produce a second swap.
        ram_rd_addr = 8'd1; step();
        ram_rd_addr = 8'd0; step();
        total++; if (frame_done !== 1'b1 || swap_pending !== 1'b0) begin bad++; $display("FAIL noswap_flags got=%b%b exp=10", frame_done, swap_pending); end
        read_px(8'd1, 24'h00ABCD, "noswap_front");
    endtask

    task automatic test_out_of_range;
        req_a = 1'b1; wr_addr_a = 8'd8; wr_data_a = 24'hFFFFFF;
        #1;
        total++; if (gnt_a !== 1'b1) begin bad++; $display("FAIL oor_gnt got=%b exp=1", gnt_a); end
        step();
        req_a = 1'b0;
        read_px(8'd8, 24'h0, "oor_read8");
        read_px(8'd255, 24'h0, "oor_read255");
        read_px(8'd0, 24'h0, "oor_no_alias");
        read_px(8'd1, 24'h00ABCD, "oor_front_intact");
        do_swap();
        read_px(8'd6, 24'h660066, "oor_after_swap");
        read_px(8'd0, 24'h0, "oor_back0");
    endtask

    task automatic test_reset_mid_clear;
        req_b = 1'b1; wr_addr_b = 8'd3; wr_data_b = 24'h333333;
        #1;
        total++; if (gnt_b !== 1'b1) begin bad++; $display("FAIL rmc_gnt_b got=%b exp=1", gnt_b); end
        step();
        req_b = 1'b0;
        swap_req = 1'b1; ram_rd_addr = 8'd1; step();
        swap_req = 1'b0; ram_rd_addr = 8'd0; step();
        repeat (3) step();
        rst_n = 1'b0;
        step();
        total++; if (swap_pending !== 1'b0 || frame_done !== 1'b0) begin bad++; $display("FAIL rmc_flags got=%b%b exp=00", swap_pending, frame_done); end
        total++; if (ram_rd_data !== 24'h0) begin bad++; $display("FAIL rmc_rd_data got=%h exp=0", ram_rd_data); end
        rst_n = 1'b1;
        req_a = 1'b1; wr_addr_a = 8'd9; wr_data_a = 24'h999999;
        #1;
        total++; if (gnt_a !== 1'b1) begin bad++; $display("FAIL rmc_fill_gnt got=%b exp=1", gnt_a); end
        step();
        req_a = 1'b0;
        // Front is buffer 0 again; the aborted clear never reached pixel 6.
        read_px(8'd6, 24'h660066, "rmc_clear_aborted");
    endtask

    initial begin
        rst_n = 1'b0;
        req_a = 1'b0; wr_addr_a = 8'd0; wr_data_a = 24'h0;
        req_b = 1'b0; wr_addr_b = 8'd0; wr_data_b = 24'h0;
        swap_req = 1'b0; ram_rd_addr = 8'd0;
        test_reset();
        test_basic_write();
        test_round_robin();
        test_swap_defer();
        test_out_of_range();
        test_reset_mid_clear();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
